// File: rtl/rst_ctrl_pkg.sv
// rtl/rst_ctrl_pkg.sv - shared FSM state and reset-cause encodings for rst_ctrl
package rst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

endpackage

// File: rtl/rst_sync.sv
// rtl/rst_sync.sv - async-assert / sync-deassert reset synchroniser chain
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst_n
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], 1'b1};
    end
  end

  assign o_rst_n = r_chain[STAGES-1];

endmodule

// File: rtl/rst_ctrl.sv
// rtl/rst_ctrl.sv - staged reset sequencer with software and watchdog reset sources
module rst_ctrl
  import rst_ctrl_pkg::*;
#(
  parameter int N_OUT       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 3,
  parameter int STAGGER     = 2,
  parameter int WDT_WIDTH   = 16,
  parameter int WDT_LIMIT   = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_rst_req,
  input  logic             wdt_en,
  input  logic             wdt_kick,
  output logic [N_OUT-1:0] rst_n_out,
  output logic [1:0]       rst_cause,
  output logic             busy
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int STG_W  = $clog2(STAGGER + 1);
  localparam int IDX_W  = $clog2(N_OUT + 1);

  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STG_W-1:0]     STG_LAST  = STG_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(N_OUT - 1);
  localparam logic [WDT_WIDTH-1:0] WDT_LAST  = WDT_WIDTH'(WDT_LIMIT - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [HOLD_W-1:0]    r_hold_cnt, w_hold_nxt;
  logic [STG_W-1:0]     r_stg_cnt, w_stg_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [WDT_WIDTH-1:0] r_wdt_cnt, w_wdt_nxt;
  logic [N_OUT-1:0]     r_rst_n_out, w_out_nxt;
  logic [1:0]           r_cause, w_cause_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 w_sync_rst_n;
  logic                 w_timeout;

  rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_rst_n (w_sync_rst_n)
  );

  assign w_timeout = (r_state == ST_RUN) && wdt_en && !wdt_kick && (r_wdt_cnt == WDT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ASSERT;
      r_hold_cnt  <= '0;
      r_stg_cnt   <= '0;
      r_idx       <= '0;
      r_wdt_cnt   <= '0;
      r_rst_n_out <= '0;
      r_cause     <= CAUSE_POR;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_stg_cnt   <= w_stg_nxt;
      r_idx       <= w_idx_nxt;
      r_wdt_cnt   <= w_wdt_nxt;
      r_rst_n_out <= w_out_nxt;
      r_cause     <= w_cause_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_stg_nxt   = r_stg_cnt;
    w_idx_nxt   = r_idx;
    w_wdt_nxt   = r_wdt_cnt;
    w_out_nxt   = r_rst_n_out;
    w_cause_nxt = r_cause;

    case (r_state)
      ST_ASSERT: begin
        w_out_nxt = '0;
        // Hold only counts once the synchronised reset has released.
        if (w_sync_rst_n) begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_hold_nxt  = '0;
            w_out_nxt   = N_OUT'(1);
            w_idx_nxt   = IDX_W'(1);
            w_stg_nxt   = '0;
            w_state_nxt = (N_OUT == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
      end

      ST_RELEASE: begin
        if (sw_rst_req) begin
          w_state_nxt = ST_ASSERT;
          w_out_nxt   = '0;
          w_hold_nxt  = '0;
          w_stg_nxt   = '0;
          w_idx_nxt   = '0;
          w_wdt_nxt   = '0;
          w_cause_nxt = CAUSE_SW;
        end else if (r_stg_cnt == STG_LAST) begin
          w_stg_nxt = '0;
          w_out_nxt = r_rst_n_out | (N_OUT'(1) << r_idx);
          w_idx_nxt = r_idx + 1'b1;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_stg_nxt = r_stg_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        // Software request outranks a coincident watchdog timeout.
        if (sw_rst_req || w_timeout) begin
          w_state_nxt = ST_ASSERT;
          w_out_nxt   = '0;
          w_hold_nxt  = '0;
          w_stg_nxt   = '0;
          w_idx_nxt   = '0;
          w_wdt_nxt   = '0;
          w_cause_nxt = sw_rst_req ? CAUSE_SW : CAUSE_WDT;
        end else if (wdt_kick) begin
          w_wdt_nxt = '0;
        end else if (wdt_en) begin
          w_wdt_nxt = r_wdt_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_ASSERT;
        w_out_nxt   = '0;
        w_hold_nxt  = '0;
        w_stg_nxt   = '0;
        w_idx_nxt   = '0;
        w_wdt_nxt   = '0;
      end
    endcase

    w_busy_nxt = ~&w_out_nxt;
  end

  assign rst_n_out = r_rst_n_out;
  assign rst_cause = r_cause;
  assign busy      = r_busy;

endmodule

// File: tb/tb_rst_ctrl.sv
// tb/tb_rst_ctrl.sv - scoreboard bench for rst_ctrl against a schedule-based reference model
module tb_rst_ctrl;

  localparam int N  = 3;
  localparam int SY = 2;
  localparam int H  = 3;
  localparam int S  = 2;
  localparam int WL = 8;

  logic         clk;
  logic         rst_n;
  logic         sw_rst_req;
  logic         wdt_en;
  logic         wdt_kick;
  logic [N-1:0] rst_n_out;
  logic [1:0]   rst_cause;
  logic         busy;

  rst_ctrl #(
    .N_OUT       (N),
    .SYNC_STAGES (SY),
    .HOLD_CYCLES (H),
    .STAGGER     (S),
    .WDT_WIDTH   (16),
    .WDT_LIMIT   (WL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (sw_rst_req),
    .wdt_en     (wdt_en),
    .wdt_kick   (wdt_kick),
    .rst_n_out  (rst_n_out),
    .rst_cause  (rst_cause),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct packed {
    logic [N-1:0] o;
    logic [1:0]   c;
    logic         b;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp;
  int   n_bad;

  // Reference model: release schedule is a pure function of edges since the origin edge.
  int         m_edge;
  int         m_origin;
  int         m_hi;
  int         m_wdt;
  bit         m_valid;
  logic [1:0] m_cause;

  function automatic int phase_at(int e);
    int t;
    if (!m_valid) return 0;
    t = e - m_origin;
    if (t < H) return 0;
    if (t < H + S * (N - 1)) return 1;
    return 2;
  endfunction

  function automatic logic [N-1:0] out_at(int e);
    logic [N-1:0] v;
    v = '0;
    if (m_valid) begin
      for (int i = 0; i < N; i++) v[i] = ((e - m_origin) >= (H + S * i));
    end
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_hi    = 0;
    m_wdt   = 0;
    m_cause = 2'b00;
  endtask

  task automatic model_step(input bit rst, input bit sw, input bit en, input bit kick);
    int   ph;
    exp_t e;
    ph = phase_at(m_edge);
    m_edge++;
    if (!rst) begin
      model_reset();
    end else if (!m_valid) begin
      m_hi++;
      if (m_hi >= SY) begin
        m_valid  = 1'b1;
        m_origin = m_edge;
      end
    end else if (ph == 1 && sw) begin
      m_origin = m_edge;
      m_cause  = 2'b01;
    end else if (ph == 2) begin
      if (sw) begin
        m_origin = m_edge;
        m_cause  = 2'b01;
        m_wdt    = 0;
      end else if (en && !kick && m_wdt == WL - 1) begin
        m_origin = m_edge;
        m_cause  = 2'b10;
        m_wdt    = 0;
      end else if (kick) begin
        m_wdt = 0;
      end else if (en) begin
        m_wdt++;
      end
    end
    e.o = out_at(m_edge);
    e.c = m_cause;
    e.b = (e.o != {N{1'b1}});
    sbq.push_back(e);
  endtask

  task automatic drive_cycle(input bit rst, input bit sw, input bit en, input bit kick);
    exp_t r;
    if (!rst && rst_n === 1'b1) begin
      r.o = '0;
      r.c = 2'b00;
      r.b = 1'b1;
      sbq.push_back(r);
      model_reset();
    end
    rst_n      = rst;
    sw_rst_req = sw;
    wdt_en     = en;
    wdt_kick   = kick;
    model_step(rst, sw, en, kick);
    @(negedge clk);
  endtask

  task automatic cyc(input bit sw, input bit en, input bit kick);
    drive_cycle(1'b1, sw, en, kick);
  endtask

  task automatic async_reset();
    #3;
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bound_fail(input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired, got no event, required within budget", what);
  endtask

  task automatic wait_run();
    int k;
    k = 0;
    while (phase_at(m_edge) != 2 && k < 60) begin
      cyc(1'b0, 1'b0, 1'b0);
      k++;
    end
    if (phase_at(m_edge) != 2) bound_fail("wait_run");
  endtask

  task automatic wait_wdt_last();
    int k;
    k = 0;
    while (!(phase_at(m_edge) == 2 && m_wdt == WL - 1) && k < 60) begin
      cyc(1'b0, 1'b1, 1'b0);
      k++;
    end
    if (!(phase_at(m_edge) == 2 && m_wdt == WL - 1)) bound_fail("wait_wdt_last");
  endtask

  initial begin
    exp_t e;
    #5;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL sb_empty t=%0t: got output %b/%b/%b, required a queued expectation",
                 $time, rst_n_out, rst_cause, busy);
      end else begin
        e = sbq.pop_front();
        if ({rst_n_out, rst_cause, busy} !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t: got out=%b cause=%b busy=%b, required out=%b cause=%b busy=%b",
                   $time, rst_n_out, rst_cause, busy, e.o, e.c, e.b);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    m_edge   = 0;
    m_origin = 0;
    model_reset();

    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (12) cyc(1'b0, 1'b0, 1'b0);

    repeat (40) cyc(1'b0, 1'b1, 1'b0);

    wait_run();
    cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, (i % 6) == 5);

    wait_wdt_last();
    cyc(1'b0, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);

    wait_run();
    cyc(1'b1, 1'b0, 1'b0);
    repeat (10) cyc(1'b0, 1'b0, 1'b0);

    wait_wdt_last();
    cyc(1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);

    begin
      int k;
      k = 0;
      while (out_at(m_edge) != 3'b001 && k < 40) begin
        cyc(1'b0, 1'b0, 1'b0);
        k++;
      end
      if (out_at(m_edge) != 3'b001) bound_fail("wait_partial_release");
    end
    cyc(1'b1, 1'b0, 1'b0);
    repeat (12) cyc(1'b0, 1'b0, 1'b0);

    wait_run();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (12) cyc(1'b0, 1'b0, 1'b0);

    wait_run();
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    async_reset();
    repeat (15) cyc(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
        if ($urandom_range(0, 1) == 1) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      end else begin
        cyc($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0);
      end
    end

    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending expectations, required 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rst_ctrl.md
RST_CTRL -- requirements
Module: rst_ctrl

Interface
REQ-001 Parameter N_OUT, default 3, number of staged reset outputs (1..8).
REQ-002 Parameter SYNC_STAGES, default 2, reset-deassert synchroniser depth (>=2).
REQ-003 Parameter HOLD_CYCLES, default 3, cycles all outputs stay asserted after the synchronised release (>=1).
REQ-004 Parameter STAGGER, default 2, cycles between successive output releases (>=1).
REQ-005 Parameter WDT_WIDTH, default 16, watchdog counter width.
REQ-006 Parameter WDT_LIMIT, default 1000, watchdog timeout count (2..2^WDT_WIDTH-1).
REQ-007 clk  in  1  single system clock, rising-edge active.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 sw_rst_req  in  1  software reset request, sampled on clk.
REQ-010 wdt_en  in  1  watchdog enable, sampled on clk.
REQ-011 wdt_kick  in  1  watchdog clear, sampled on clk.
REQ-012 rst_n_out  out  N_OUT  per-domain active-low resets; bit 0 released first.
REQ-013 rst_cause  out  2  last reset cause: 00 power-on, 01 software, 10 watchdog.
REQ-014 busy  out  1  high while any rst_n_out bit is low.

Function
REQ-015 FSM states ASSERT, RELEASE, RUN; all outputs are registered.
REQ-016 rst_n is synchronised through SYNC_STAGES flops; edge E0 is the first edge at which the synchroniser output is 1.
REQ-017 ASSERT: all rst_n_out low, hold counter increments; ASSERT exits to RELEASE after HOLD_CYCLES cycles.
REQ-018 rst_n_out[i] goes high at edge E0+HOLD_CYCLES+STAGGER*i; FSM enters RUN and busy falls on the same edge rst_n_out[N_OUT-1] rises.
REQ-019 RUN: watchdog counter increments by 1 per cycle when wdt_en=1, holds when wdt_en=0, clears to 0 on wdt_kick=1.
REQ-020 Watchdog timeout is the cycle counter value equals WDT_LIMIT-1 with wdt_en=1 and wdt_kick=0; next edge enters ASSERT, rst_cause=10.
REQ-021 sw_rst_req=1 in RUN: next edge enters ASSERT, rst_cause=01.
REQ-022 Simultaneous sw_rst_req and timeout: software wins, rst_cause=01.
REQ-023 Simultaneous wdt_kick and timeout condition: kick wins, no reset.
REQ-024 sw_rst_req in RELEASE: all rst_n_out re-assert on the next edge, FSM returns to ASSERT, hold counter restarts, rst_cause=01.
REQ-025 sw_rst_req in ASSERT: ignored; hold counter not restarted.
REQ-026 Internally generated resets re-enter ASSERT directly (no synchroniser delay); HOLD_CYCLES and STAGGER timing per REQ-017/018 apply from that edge.
REQ-027 Watchdog counter clears on every ASSERT entry and never counts outside RUN.
REQ-028 All counters saturate-free: width sized from parameters with $clog2; no wrap occurs for legal parameters.

Reset
REQ-029 rst_n low asynchronously forces: rst_n_out all 0, busy 1, rst_cause 00, state ASSERT, all counters 0, synchroniser flops 0.
REQ-030 rst_n low mid-RUN or mid-RELEASE takes effect immediately, independent of clk.
REQ-031 Deassertion of rst_n is only seen through the synchroniser (REQ-016).

Structure
REQ-032 Package rst_ctrl_pkg holds the state enum and the rst_cause code constants (CAUSE_POR, CAUSE_SW, CAUSE_WDT).
REQ-033 Sub-module rst_sync implements the SYNC_STAGES async-assert/sync-deassert chain; rst_ctrl instantiates it once.

Verification (N_OUT=3, SYNC_STAGES=2, HOLD_CYCLES=3, STAGGER=2, WDT_LIMIT=8, 20 ns clk)
REQ-034 Power-on: rst_n low 1 cycle then high -> rst_n_out 000, then 001 at E0+3, 011 at E0+5, 111 at E0+7; busy falls at E0+7; rst_cause=00.
REQ-035 Watchdog: RUN, wdt_en=1, no kick -> after 8 counting cycles rst_n_out=000, rst_cause=10, re-release 3/5/7 cycles later.
REQ-036 Kick: wdt_kick pulsed every 6 cycles for 100 cycles -> rst_n_out stays 111; kick coincident with count 7 -> no reset.
REQ-037 Software: sw_rst_req 1 cycle in RUN -> next edge rst_n_out=000, rst_cause=01; sw_rst_req in same cycle as timeout -> rst_cause=01.
REQ-038 Mid-release: sw_rst_req when rst_n_out=001 -> next edge 000, release sequence restarts with full HOLD_CYCLES; sw_rst_req during ASSERT -> timing unchanged.
REQ-039 Async: rst_n pulled low between clk edges in RUN -> rst_n_out=000 and rst_cause=00 before the next edge.
